// File: rtl/uart_pkg.sv
// Shared types and widths for the UART baud scheduler and its period generator.
package uart_pkg;

   localparam int unsigned IBRD_W = 24;
   localparam int unsigned FBRD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2,
      LOAD = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [IBRD_W-1:0] ibrd;
      logic [FBRD_W-1:0] fbrd;
   } baud_div_t;

endpackage

// File: rtl/uart_baud_sched_if.sv
// Control, divisor-write and tick/status bundle between the register side and the scheduler.
interface uart_baud_sched_if;
   import uart_pkg::*;

   logic              enable;
   logic              cfg_wr;
   logic [IBRD_W-1:0] cfg_ibrd;
   logic [FBRD_W-1:0] cfg_fbrd;
   logic              tx_busy;
   logic              rx_busy;
   logic              tick16;
   logic              tick_tx;
   logic              cfg_pending;
   logic              cfg_ack;
   logic              cfg_err;
   logic [IBRD_W-1:0] active_ibrd;
   logic [FBRD_W-1:0] active_fbrd;

   modport master (
      output enable, cfg_wr, cfg_ibrd, cfg_fbrd, tx_busy, rx_busy,
      input  tick16, tick_tx, cfg_pending, cfg_ack, cfg_err, active_ibrd, active_fbrd
   );

   modport slave (
      input  enable, cfg_wr, cfg_ibrd, cfg_fbrd, tx_busy, rx_busy,
      output tick16, tick_tx, cfg_pending, cfg_ack, cfg_err, active_ibrd, active_fbrd
   );

endinterface

// File: rtl/uart_frac_period.sv
// Oversample period counter; with UART_BAUD_FRAC_EN a fractional accumulator stretches
// a period by one clock whenever the accumulated fraction overflows.
module uart_frac_period
   import uart_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic [IBRD_W-1:0] ibrd_i,
   input  logic [FBRD_W-1:0] fbrd_i,
   output logic              fire_o,
   output logic              tick_o
);
   localparam int unsigned CW = IBRD_W + 1;

   logic [IBRD_W-1:0] cnt_q, cnt_d;
   logic              tick_q;
   logic              carry;

`ifdef UART_BAUD_FRAC_EN
   logic [FBRD_W-1:0] acc_q;
   logic              carry_q;
   logic [FBRD_W:0]   sum;

   assign sum   = {1'b0, acc_q} + {1'b0, fbrd_i};
   assign carry = carry_q;

   // The carry produced at the end of one period lengthens the following one.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
      end else if (fire_o) begin
         acc_q   <= sum[FBRD_W-1:0];
         carry_q <= sum[FBRD_W];
      end
   end
`else
   logic unused_fbrd;
   assign unused_fbrd = ^fbrd_i;
   assign carry       = 1'b0;
`endif

   // Compared in CW bits so ibrd = 2^24-1 plus a carry cannot wrap.
   assign fire_o = (CW'(cnt_q) + CW'(1)) == (CW'(ibrd_i) + CW'(carry));
   assign cnt_d  = fire_o ? '0 : cnt_q + 1'b1;
   assign tick_o = tick_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= fire_o;
      end
   end

endmodule

// File: rtl/uart_baud_sched.sv
// Baud scheduler: owns the active divisor, sequences divisor writes onto idle tick
// boundaries and divides tick16 down to tick_tx. Fractional timing needs UART_BAUD_FRAC_EN.
module uart_baud_sched
   import uart_pkg::*;
#(
   parameter int unsigned RESET_IBRD = 27,
   parameter int unsigned RESET_FBRD = 32,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   uart_baud_sched_if.slave bus
);
   localparam int unsigned DIV_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

   sched_state_e state_q;
   baud_div_t    act_q, pend_q, wr_div;
   logic         pending_q, ack_q, err_q, tick_tx_q;
   logic [DIV_W-1:0] div_q;
   logic         tick16, fire, clr, wr_ok, wr_bad, go_load;

   assign wr_div  = '{ibrd: bus.cfg_ibrd, fbrd: bus.cfg_fbrd};
   assign wr_ok   = bus.cfg_wr && (bus.cfg_ibrd != '0);
   assign wr_bad  = bus.cfg_wr && (bus.cfg_ibrd == '0);
   assign go_load = (state_q == PEND) && bus.enable && tick16 && !bus.tx_busy && !bus.rx_busy;
   // Clearing on entry to LOAD makes the LOAD cycle the first clock of the new period.
   assign clr     = !bus.enable || (state_q == IDLE) || go_load;

   uart_frac_period u_period (
      .clk_i  (clock_i),
      .rst_i  (reset_i),
      .clr_i  (clr),
      .ibrd_i (act_q.ibrd),
      .fbrd_i (act_q.fbrd),
      .fire_o (fire),
      .tick_o (tick16)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         act_q     <= '{ibrd: IBRD_W'(RESET_IBRD), fbrd: FBRD_W'(RESET_FBRD)};
         pend_q    <= '0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         tick_tx_q <= 1'b0;
         div_q     <= '0;
      end else begin
         ack_q     <= 1'b0;
         err_q     <= wr_bad;
         tick_tx_q <= fire && !clr && (div_q == DIV_W'(OVERSAMPLE - 1));
         if (clr)       div_q <= '0;
         else if (fire) div_q <= div_q + 1'b1;

         if (!bus.enable) begin
            // Stopped: nothing in flight, so any write (held or new) applies at once.
            state_q <= IDLE;
            if (pending_q || wr_ok) begin
               act_q     <= wr_ok ? wr_div : pend_q;
               ack_q     <= 1'b1;
               pending_q <= 1'b0;
            end
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q <= RUN;
                  if (wr_ok) begin
                     act_q <= wr_div;
                     ack_q <= 1'b1;
                  end
               end
               RUN: begin
                  if (wr_ok) begin
                     pend_q    <= wr_div;
                     pending_q <= 1'b1;
                     state_q   <= PEND;
                  end
               end
               PEND: begin
                  if (go_load) begin
                     act_q     <= pend_q;
                     ack_q     <= 1'b1;
                     pending_q <= 1'b0;
                     state_q   <= LOAD;
                  end
                  if (wr_ok) begin
                     pend_q    <= wr_div;
                     pending_q <= 1'b1;
                  end
               end
               LOAD: begin
                  if (wr_ok) begin
                     pend_q    <= wr_div;
                     pending_q <= 1'b1;
                  end
                  state_q <= (pending_q || wr_ok) ? PEND : RUN;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.tick16      = tick16;
   assign bus.tick_tx     = tick_tx_q;
   assign bus.cfg_pending = pending_q;
   assign bus.cfg_ack     = ack_q;
   assign bus.cfg_err     = err_q;
   assign bus.active_ibrd = act_q.ibrd;
   assign bus.active_fbrd = act_q.fbrd;

endmodule
